// File: rtl/seg_pkg.sv
// Shared types and sizes for the display-source scheduler.
package seg_pkg;

  localparam int DISP_W    = 20;
  localparam int PT_W      = 6;
  localparam int NSRC      = 3;
  localparam int ALARM_IDX = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

endpackage

// File: rtl/seg_src_pick.sv
// Combinational source pick: the alarm source wins outright, otherwise the
// two low-priority sources round-robin starting after the last one granted.
module seg_src_pick
  import seg_pkg::*;
(
  input  logic [NSRC-1:0] req,
  input  logic            last_lo,
  output logic            pick_vld,
  output logic [NSRC-1:0] pick_oh
);

  always_comb begin
    pick_oh = '0;
    if (req[ALARM_IDX]) begin
      pick_oh[ALARM_IDX] = 1'b1;
    end else if (last_lo) begin
      if (req[0])      pick_oh[0] = 1'b1;
      else if (req[1]) pick_oh[1] = 1'b1;
    end else begin
      if (req[1])      pick_oh[1] = 1'b1;
      else if (req[0]) pick_oh[0] = 1'b1;
    end
  end

  assign pick_vld = |req;

endmodule

// File: rtl/seg_disp_sched.sv
// Shares one seven-segment scan driver among two round-robin sources and one
// preempting alarm source, with a blanking gap at every handover.
module seg_disp_sched
  import seg_pkg::*;
#(
  parameter logic [27:0] DWELL_MAX = 28'd149_999_999,
  parameter logic [19:0] BLANK_MAX = 20'd499_999
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [NSRC-1:0]   req,
  input  logic [DISP_W-1:0] data0,
  input  logic [DISP_W-1:0] data1,
  input  logic [DISP_W-1:0] data2,
  input  logic [PT_W-1:0]   point0,
  input  logic [PT_W-1:0]   point1,
  input  logic [PT_W-1:0]   point2,
  input  logic              sign0,
  input  logic              sign1,
  input  logic              sign2,
  input  logic              key_next,
  output logic [DISP_W-1:0] data,
  output logic [PT_W-1:0]   point,
  output logic              sign,
  output logic              seg_en,
  output logic [NSRC-1:0]   gnt
);

  state_t        state;
  logic [27:0]   dwell_cnt;
  logic [19:0]   blank_cnt;
  logic          last_lo;

  logic            pick_vld;
  logic [NSRC-1:0] pick_oh;

  logic [DISP_W-1:0] src_data  [NSRC];
  logic [PT_W-1:0]   src_point [NSRC];
  logic [NSRC-1:0]   src_sign;

  logic [DISP_W-1:0] pick_data, own_data;
  logic [PT_W-1:0]   pick_point, own_point;
  logic              pick_sign, own_sign;

  logic owner_drop, preempt, lo_owner, other_lo_req, slot_end, rotate, go_show;

  seg_src_pick u_pick (
    .req      (req),
    .last_lo  (last_lo),
    .pick_vld (pick_vld),
    .pick_oh  (pick_oh)
  );

  assign src_data[0]  = data0;
  assign src_data[1]  = data1;
  assign src_data[2]  = data2;
  assign src_point[0] = point0;
  assign src_point[1] = point1;
  assign src_point[2] = point2;
  assign src_sign     = {sign2, sign1, sign0};

  // Two one-hot muxes: the incoming pick (on grant) and the current owner (live copy).
  always_comb begin
    pick_data  = '0;
    pick_point = '0;
    pick_sign  = 1'b0;
    own_data   = '0;
    own_point  = '0;
    own_sign   = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (pick_oh[i]) begin
        pick_data  = src_data[i];
        pick_point = src_point[i];
        pick_sign  = src_sign[i];
      end
      if (gnt[i]) begin
        own_data  = src_data[i];
        own_point = src_point[i];
        own_sign  = src_sign[i];
      end
    end
  end

  // gnt doubles as the owner register while in SHOW.
  assign owner_drop   = ~|(gnt & req);
  assign preempt      = req[ALARM_IDX] & ~gnt[ALARM_IDX];
  assign lo_owner     = gnt[0] | gnt[1];
  assign other_lo_req = (gnt[0] & req[1]) | (gnt[1] & req[0]);
  assign slot_end     = lo_owner & ((dwell_cnt == DWELL_MAX) | key_next);
  assign rotate       = slot_end & other_lo_req;
  assign go_show      = pick_vld & ((state == ST_IDLE) |
                                    ((state == ST_BLANK) & (blank_cnt == BLANK_MAX)));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      dwell_cnt <= '0;
      blank_cnt <= '0;
      last_lo   <= 1'b1;
      data      <= '0;
      point     <= '0;
      sign      <= 1'b0;
      seg_en    <= 1'b0;
      gnt       <= '0;
    end else if (go_show) begin
      state     <= ST_SHOW;
      gnt       <= pick_oh;
      seg_en    <= 1'b1;
      data      <= pick_data;
      point     <= pick_point;
      sign      <= pick_sign;
      dwell_cnt <= '0;
      blank_cnt <= '0;
      if (!pick_oh[ALARM_IDX]) last_lo <= pick_oh[1];
    end else begin
      case (state)
        ST_IDLE: begin
          dwell_cnt <= '0;
          blank_cnt <= '0;
        end
        ST_SHOW: begin
          if (owner_drop || preempt || rotate) begin
            state     <= ST_BLANK;
            gnt       <= '0;
            seg_en    <= 1'b0;
            dwell_cnt <= '0;
            blank_cnt <= '0;
          end else begin
            data  <= own_data;
            point <= own_point;
            sign  <= own_sign;
            // Lone low source at slot end simply restarts its slot.
            if (slot_end)                    dwell_cnt <= '0;
            else if (dwell_cnt != DWELL_MAX) dwell_cnt <= dwell_cnt + 28'd1;
          end
        end
        ST_BLANK: begin
          if (blank_cnt == BLANK_MAX) begin
            state     <= ST_IDLE;
            blank_cnt <= '0;
          end else begin
            blank_cnt <= blank_cnt + 20'd1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          gnt    <= '0;
          seg_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
